// File: rtl/ssd1306_spi_driver.sv
// ssd1306_spi_driver: panel reset, init command list, then pixel bytes and
// frame-sync command bursts to an SSD1306 128x32 over 4-wire SPI (mode 0).
module ssd1306_spi_driver #(
    parameter int CLK_DIV      = 4,
    parameter int RESET_CYCLES = 1000
) (
    input  logic       clk_in,
    input  logic       reset_n_in,
    input  logic [7:0] data_in,
    input  logic       write_stb_in,
    input  logic       sync_stb_in,
    output logic       ready_out,
    output logic       oled_sclk_out,
    output logic       oled_mosi_out,
    output logic       oled_cs_n_out,
    output logic       oled_dc_out,
    output logic       oled_res_n_out
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int RST_W = $clog2(RESET_CYCLES + 1);
    localparam logic [4:0] INIT_LAST = 5'd24;
    localparam logic [2:0] SYNC_LAST = 3'd5;

    typedef enum logic [2:0] {
        S_RST_LOW,
        S_RST_WAIT,
        S_INIT,
        S_IDLE,
        S_DATA,
        S_SYNC
    } state_t;

    // Phase of the byte currently on the wire
    typedef enum logic [1:0] {
        P_LOW,
        P_HIGH,
        P_GAP
    } phase_t;

    state_t           state;
    phase_t           phase;
    logic [RST_W-1:0] rst_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_cnt;
    logic [6:0]       shreg;       // bits still to be shifted out after the current one
    logic [4:0]       init_idx;
    logic [2:0]       sync_idx;

    logic             div_last;
    logic             rst_last;
    logic             byte_done;
    logic             start_byte;
    logic [7:0]       start_val;
    logic             start_dc;

    // Fixed SSD1306 power-up configuration for a 128x32 panel
    function automatic logic [7:0] init_rom(input logic [4:0] idx);
        case (idx)
            5'd0:    init_rom = 8'hAE;
            5'd1:    init_rom = 8'hD5;
            5'd2:    init_rom = 8'h80;
            5'd3:    init_rom = 8'hA8;
            5'd4:    init_rom = 8'h1F;
            5'd5:    init_rom = 8'hD3;
            5'd6:    init_rom = 8'h00;
            5'd7:    init_rom = 8'h40;
            5'd8:    init_rom = 8'h8D;
            5'd9:    init_rom = 8'h14;
            5'd10:   init_rom = 8'h20;
            5'd11:   init_rom = 8'h00;
            5'd12:   init_rom = 8'hA1;
            5'd13:   init_rom = 8'hC8;
            5'd14:   init_rom = 8'hDA;
            5'd15:   init_rom = 8'h02;
            5'd16:   init_rom = 8'h81;
            5'd17:   init_rom = 8'h8F;
            5'd18:   init_rom = 8'hD9;
            5'd19:   init_rom = 8'hF1;
            5'd20:   init_rom = 8'hDB;
            5'd21:   init_rom = 8'h40;
            5'd22:   init_rom = 8'hA4;
            5'd23:   init_rom = 8'hA6;
            5'd24:   init_rom = 8'hAF;
            default: init_rom = 8'h00;
        endcase
    endfunction

    // Column 0..127, page 0..3: rewinds the GDDRAM pointer to the frame origin
    function automatic logic [7:0] sync_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    sync_rom = 8'h21;
            3'd1:    sync_rom = 8'h00;
            3'd2:    sync_rom = 8'h7F;
            3'd3:    sync_rom = 8'h22;
            3'd4:    sync_rom = 8'h00;
            3'd5:    sync_rom = 8'h03;
            default: sync_rom = 8'h00;
        endcase
    endfunction

    assign div_last  = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign rst_last  = (rst_cnt == RST_W'(RESET_CYCLES - 1));
    assign byte_done = (phase == P_GAP) && div_last;

    // Decide whether a new byte goes on the wire at the next edge, and which
    always_comb begin
        start_byte = 1'b0;
        start_val  = 8'h00;
        start_dc   = 1'b0;
        case (state)
            S_RST_WAIT: if (rst_last) begin
                start_byte = 1'b1;
                start_val  = init_rom(5'd0);
            end
            S_INIT: if (byte_done && init_idx != INIT_LAST) begin
                start_byte = 1'b1;
                start_val  = init_rom(init_idx + 5'd1);
            end
            S_SYNC: if (byte_done && sync_idx != SYNC_LAST) begin
                start_byte = 1'b1;
                start_val  = sync_rom(sync_idx + 3'd1);
            end
            S_IDLE: begin
                // sync has priority; a simultaneous write is dropped
                if (sync_stb_in) begin
                    start_byte = 1'b1;
                    start_val  = sync_rom(3'd0);
                end else if (write_stb_in) begin
                    start_byte = 1'b1;
                    start_val  = data_in;
                    start_dc   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Sequencer FSM plus SPI byte engine; all pin outputs are registered
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state          <= S_RST_LOW;
            phase          <= P_LOW;
            rst_cnt        <= '0;
            div_cnt        <= '0;
            bit_cnt        <= '0;
            shreg          <= '0;
            init_idx       <= '0;
            sync_idx       <= '0;
            ready_out      <= 1'b0;
            oled_sclk_out  <= 1'b0;
            oled_mosi_out  <= 1'b0;
            oled_cs_n_out  <= 1'b1;
            oled_dc_out    <= 1'b0;
            oled_res_n_out <= 1'b0;
        end else begin
            // Byte engine: load drives cycle 0 (cs_n low, dc, bit7) directly
            if (start_byte) begin
                oled_cs_n_out <= 1'b0;
                oled_sclk_out <= 1'b0;
                oled_mosi_out <= start_val[7];
                oled_dc_out   <= start_dc;
                shreg         <= start_val[6:0];
                bit_cnt       <= '0;
                div_cnt       <= '0;
                phase         <= P_LOW;
            end else if (state == S_INIT || state == S_DATA || state == S_SYNC) begin
                case (phase)
                    P_LOW: begin
                        if (div_last) begin
                            div_cnt       <= '0;
                            oled_sclk_out <= 1'b1;
                            phase         <= P_HIGH;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    P_HIGH: begin
                        if (div_last) begin
                            div_cnt       <= '0;
                            oled_sclk_out <= 1'b0;
                            bit_cnt       <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                // last falling edge: release cs_n for the gap
                                oled_cs_n_out <= 1'b1;
                                phase         <= P_GAP;
                            end else begin
                                oled_mosi_out <= shreg[6];
                                shreg         <= {shreg[5:0], 1'b0};
                                phase         <= P_LOW;
                            end
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    P_GAP: begin
                        if (div_last) begin
                            div_cnt <= '0;
                            phase   <= P_LOW;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    default: phase <= P_LOW;
                endcase
            end

            // Sequencing between bytes and phases
            case (state)
                S_RST_LOW: begin
                    if (rst_last) begin
                        rst_cnt        <= '0;
                        oled_res_n_out <= 1'b1;
                        state          <= S_RST_WAIT;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                S_RST_WAIT: begin
                    if (rst_last) begin
                        rst_cnt  <= '0;
                        init_idx <= '0;
                        state    <= S_INIT;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                S_INIT: begin
                    if (byte_done) begin
                        if (init_idx == INIT_LAST) begin
                            init_idx  <= '0;
                            ready_out <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            init_idx <= init_idx + 5'd1;
                        end
                    end
                end
                S_IDLE: begin
                    if (sync_stb_in) begin
                        sync_idx  <= '0;
                        ready_out <= 1'b0;
                        state     <= S_SYNC;
                    end else if (write_stb_in) begin
                        ready_out <= 1'b0;
                        state     <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (byte_done) begin
                        ready_out <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_SYNC: begin
                    if (byte_done) begin
                        if (sync_idx == SYNC_LAST) begin
                            sync_idx  <= '0;
                            ready_out <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            sync_idx <= sync_idx + 3'd1;
                        end
                    end
                end
                default: state <= S_RST_LOW;
            endcase
        end
    end

endmodule

// File: tb/tb_ssd1306_spi_driver.sv
// tb_ssd1306_spi_driver: directed vectors against an SPI byte monitor.
module tb_ssd1306_spi_driver;

    localparam int CLK_DIV      = 2;
    localparam int RESET_CYCLES = 8;
    localparam int BYTE_CYC     = 17 * CLK_DIV;

    logic       clk_in       = 1'b0;
    logic       reset_n_in   = 1'b1;
    logic [7:0] data_in      = 8'h00;
    logic       write_stb_in = 1'b0;
    logic       sync_stb_in  = 1'b0;
    logic       ready_out;
    logic       oled_sclk_out;
    logic       oled_mosi_out;
    logic       oled_cs_n_out;
    logic       oled_dc_out;
    logic       oled_res_n_out;

    ssd1306_spi_driver #(.CLK_DIV(CLK_DIV), .RESET_CYCLES(RESET_CYCLES)) dut (
        .clk_in        (clk_in),
        .reset_n_in    (reset_n_in),
        .data_in       (data_in),
        .write_stb_in  (write_stb_in),
        .sync_stb_in   (sync_stb_in),
        .ready_out     (ready_out),
        .oled_sclk_out (oled_sclk_out),
        .oled_mosi_out (oled_mosi_out),
        .oled_cs_n_out (oled_cs_n_out),
        .oled_dc_out   (oled_dc_out),
        .oled_res_n_out(oled_res_n_out)
    );

    always #5 clk_in = ~clk_in;

    logic [7:0] init_tab [25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h1F, 8'hD3, 8'h00, 8'h40,
                                  8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h02,
                                  8'h81, 8'h8F, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6,
                                  8'hAF};
    logic [7:0] sync_tab [6]  = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h03};

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // SPI slave model: sample mosi on sclk rise while selected
    logic [7:0] byte_q [$];
    logic       dc_q [$];
    int         gap_q [$];
    int         mon_bits = 0;
    logic [7:0] mon_sh   = 8'h00;
    logic       mon_dc0  = 1'b0;
    int         dc_bad   = 0;
    int         hi_run   = 0;

    // Collect bytes; a cs_n rise discards any partial byte
    always @(posedge oled_sclk_out or posedge oled_cs_n_out) begin
        if (oled_cs_n_out) begin
            mon_bits = 0;
        end else begin
            if (mon_bits == 0) mon_dc0 = oled_dc_out;
            else if (oled_dc_out !== mon_dc0) dc_bad++;
            mon_sh = {mon_sh[6:0], oled_mosi_out};
            mon_bits++;
            if (mon_bits == 8) begin
                byte_q.push_back(mon_sh);
                dc_q.push_back(mon_dc0);
                mon_bits = 0;
            end
        end
    end

    // Record length of every cs_n-high stretch, logged when cs_n falls
    always @(negedge clk_in) begin
        if (oled_cs_n_out) begin
            hi_run++;
        end else begin
            if (hi_run > 0) gap_q.push_back(hi_run);
            hi_run = 0;
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic reset_and_init(input bit poke_strobes);
        int n;
        int base;
        int bad;
        base = byte_q.size();
        reset_n_in = 1'b0;
        repeat (3) tick();
        chk("reset_state", {ready_out, oled_sclk_out, oled_mosi_out, oled_cs_n_out,
                            oled_dc_out, oled_res_n_out}, 6'b000100);
        reset_n_in = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!oled_res_n_out && n < 50);
        chk("res_low_cycles", n, RESET_CYCLES);
        n = 0;
        do begin tick(); n++; end while (oled_cs_n_out && n < 50);
        chk("res_high_cycles", n, RESET_CYCLES);
        n = 0;
        do begin
            tick();
            n++;
            if (poke_strobes && n == 100) begin
                data_in = 8'h77; write_stb_in = 1'b1; sync_stb_in = 1'b1;
            end else if (n == 102) begin
                write_stb_in = 1'b0; sync_stb_in = 1'b0;
            end
        end while (!ready_out && n < 2000);
        chk("init_latency", n, 25 * BYTE_CYC);
        chk("init_count", byte_q.size() - base, 25);
        if (byte_q.size() > base) chk("init_first", byte_q[base], 8'hAE);
        bad = 0;
        for (int i = 0; i < 25; i++)
            if (base + i >= byte_q.size() || byte_q[base+i] !== init_tab[i] || dc_q[base+i] !== 1'b0)
                bad++;
        chk("init_seq_bad", bad, 0);
    endtask

    // Issue one strobe from idle; lat counts from accept cycle to ready high
    task automatic send(input logic [7:0] d, input bit wr, input bit sy, output int lat);
        data_in = d; write_stb_in = wr; sync_stb_in = sy;
        tick();
        chk("ready_drop", ready_out, 1'b0);
        chk("start_pins", {oled_cs_n_out, oled_dc_out, oled_mosi_out},
            {1'b0, sy ? 1'b0 : 1'b1, sy ? 1'b0 : d[7]});
        write_stb_in = 1'b0; sync_stb_in = 1'b0; data_in = 8'h00;
        lat = 1;
        while (!ready_out && lat < 2000) begin tick(); lat++; end
    endtask

    task automatic check_sync(input string tag, input int base, input int gbase);
        int bad;
        chk({tag, "_count"}, byte_q.size() - base, 6);
        bad = 0;
        for (int i = 0; i < 6; i++)
            if (base + i >= byte_q.size() || byte_q[base+i] !== sync_tab[i] || dc_q[base+i] !== 1'b0)
                bad++;
        chk({tag, "_seq_bad"}, bad, 0);
        chk({tag, "_gap_count"}, gap_q.size() - gbase, 6);
        bad = 0;
        for (int i = 1; i < 6; i++)
            if (gbase + i >= gap_q.size() || gap_q[gbase+i] != CLK_DIV) bad++;
        chk({tag, "_gap_bad"}, bad, 0);
    endtask

    initial begin
        int lat;
        int base;
        int gbase;
        #2;
        // Reset + init, with strobes poked while busy
        reset_and_init(1'b1);

        // Single data byte
        base = byte_q.size();
        send(8'hA5, 1'b1, 1'b0, lat);
        chk("write_latency", lat, 1 + BYTE_CYC);
        chk("write_count", byte_q.size() - base, 1);
        if (byte_q.size() > base) begin
            chk("write_byte", byte_q[base], 8'hA5);
            chk("write_dc", dc_q[base], 1'b1);
        end

        // Frame sync
        base = byte_q.size(); gbase = gap_q.size();
        repeat (3) tick();
        send(8'h00, 1'b0, 1'b1, lat);
        chk("sync_latency", lat, 1 + 6 * BYTE_CYC);
        check_sync("sync", base, gbase);

        // Write and sync together: only the sync burst goes out
        base = byte_q.size(); gbase = gap_q.size();
        repeat (3) tick();
        send(8'hEE, 1'b1, 1'b1, lat);
        chk("both_latency", lat, 1 + 6 * BYTE_CYC);
        check_sync("both", base, gbase);

        // Write strobe held across the busy period
        base = byte_q.size();
        data_in = 8'h3C; write_stb_in = 1'b1;
        tick();
        chk("held_ready_drop", ready_out, 1'b0);
        lat = 1;
        while (!ready_out && lat < 2000) begin tick(); lat++; end
        chk("held_latency", lat, 1 + BYTE_CYC);
        chk("held_one_byte", byte_q.size() - base, 1);
        tick();
        chk("held_reaccept", ready_out, 1'b0);
        write_stb_in = 1'b0;
        lat = 1;
        while (!ready_out && lat < 2000) begin tick(); lat++; end
        chk("held_total", byte_q.size() - base, 2);
        if (byte_q.size() >= base + 2) chk("held_bytes", {byte_q[base], byte_q[base+1]}, 16'h3C3C);

        // Reset mid-byte, then full replay
        data_in = 8'hFF; write_stb_in = 1'b1;
        tick();
        write_stb_in = 1'b0;
        repeat (9) tick();
        chk("midbyte_busy", {oled_cs_n_out, ready_out}, 2'b00);
        reset_n_in = 1'b0;
        #1;
        chk("midbyte_reset", {oled_cs_n_out, oled_sclk_out, ready_out, oled_res_n_out}, 4'b1000);
        reset_and_init(1'b0);

        chk("dc_stable", dc_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
